playback_sequencer: RTL and testbench

- Steps through the stored composition one position at a time and drives the current note to the tone generator.
- Reads each note from the composition note memory through a registered read port with a fixed 1-cycle latency.
- Holds each note for a programmable number of clock ticks, then inserts a silent articulation gap.
- Exports the playback position so the note display can highlight it. It yields the memory to the editor (place/delete) whenever edit_busy is high.

---
 rtl/playback_sequencer.sv | 176 +++++++++++++++++
 tb/tb_playback_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_sequencer.sv
// playback_sequencer
//   Walks the stored composition one position at a time. Each note is read
//   from the note memory (registered read port, 1-cycle latency), held for
//   beat_len clocks, then followed by GAP_TICKS silent clocks before the
//   next position is fetched. Reads are suppressed while the editor owns the
//   memory (edit_busy).
//
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   play       level, starts playback from position 0 when idle
//   stop       level, aborts playback on the next edge (beats play)
//   loop_en    at end of song restart from position 0 instead of finishing
//   beat_len   note duration in clocks, sampled as each note loads
//   edit_busy  editor owns the note memory, no reads may be issued
//   rd_en      note memory read strobe (registered)
//   rd_addr    note memory read address (registered)
//   rd_data    note memory data, valid the cycle after rd_en
//   note_out   current note code to the tone generator
//   note_valid tone enable, low during rests, gaps and idle
//   play_pos   position currently playing or being fetched
//   playing    high in every non-idle state
//   done       one-cycle pulse when playback finishes naturally
module playback_sequencer #(
  parameter int NUM_POS   = 64,
  parameter int POS_W     = 6,
  parameter int NOTE_W    = 6,
  parameter int END_CODE  = 63,
  parameter int GAP_TICKS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [23:0]       beat_len,
  input  logic              edit_busy,
  output logic              rd_en,
  output logic [POS_W-1:0]  rd_addr,
  input  logic [NOTE_W-1:0] rd_data,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic [POS_W-1:0]  play_pos,
  output logic              playing,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(NUM_POS - 1);
  localparam logic [NOTE_W-1:0] END_NOTE = NOTE_W'(END_CODE);
  localparam logic [23:0]       GAP_LOAD = (GAP_TICKS > 0) ? 24'(GAP_TICKS - 1) : '0;

  state_t      state;
  logic [23:0] cnt;

  logic at_last;
  logic advance;
  logic song_end;
  logic next_read;

  // play_pos doubles as the working position register.
  always_comb begin
    at_last   = (play_pos == LAST_POS);
    advance   = ((state == S_PLAY) && (cnt == '0) && (GAP_TICKS == 0)) ||
                ((state == S_GAP)  && (cnt == '0));
    song_end  = ((state == S_WAIT) && !rd_en && (rd_data == END_NOTE)) ||
                (advance && at_last);
    next_read = advance && !at_last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      note_out   <= '0;
      note_valid <= 1'b0;
      play_pos   <= '0;
      playing    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state != S_IDLE) && stop) begin
        state      <= S_IDLE;
        rd_en      <= 1'b0;
        note_valid <= 1'b0;
        play_pos   <= '0;
        playing    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (play && !stop) begin
              state    <= S_FETCH;
              play_pos <= '0;
              playing  <= 1'b1;
            end
          end
          S_FETCH: begin
            if (!edit_busy) begin
              rd_en   <= 1'b1;
              rd_addr <= play_pos;
              state   <= S_WAIT;
            end
          end
          // WAIT spans two edges: the first is the memory's capture edge
          // (rd_en still high), the second samples the returned note.
          S_WAIT: begin
            if (rd_en) begin
              rd_en <= 1'b0;
            end else if (rd_data != END_NOTE) begin
              note_out   <= rd_data;
              note_valid <= (rd_data != '0);
              cnt        <= (beat_len == '0) ? '0 : beat_len - 24'd1;
              state      <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (cnt != '0) begin
              cnt <= cnt - 24'd1;
            end else if (GAP_TICKS != 0) begin
              note_valid <= 1'b0;
              cnt        <= GAP_LOAD;
              state      <= S_GAP;
            end
          end
          S_GAP: begin
            if (cnt != '0) begin
              cnt <= cnt - 24'd1;
            end
          end
          S_DONE: begin
            state   <= S_IDLE;
            playing <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase

        // Advancing issues the next read on the same edge when the memory is
        // free, folding the FETCH cycle into the end of the note so the note
        // period stays beat_len + GAP_TICKS + 2.
        if (next_read) begin
          play_pos <= play_pos + 1'b1;
          if (edit_busy) begin
            state <= S_FETCH;
          end else begin
            rd_en   <= 1'b1;
            rd_addr <= play_pos + 1'b1;
            state   <= S_WAIT;
          end
        end

        // END_CODE at position 0 never loops, so an empty song cannot spin.
        if (song_end) begin
          play_pos <= '0;
          if (loop_en && (play_pos != '0)) begin
            state <= S_FETCH;
          end else begin
            state      <= S_DONE;
            done       <= 1'b1;
            note_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_playback_sequencer.sv
module tb_playback_sequencer;

  logic       clk;
  logic       rst_n;

  // main instance, GAP_TICKS = 2
  logic       play, stop, loop_en, edit_busy;
  logic [23:0] beat_len;
  logic       rd_en;
  logic [5:0] rd_addr, rd_data, note_out, play_pos;
  logic       note_valid, playing, done;
  logic [5:0] mem_a [0:63];

  // legato instance, GAP_TICKS = 0
  logic       l_play, l_stop, l_loop_en;
  logic [23:0] l_beat_len;
  logic       l_rd_en;
  logic [5:0] l_rd_addr, l_rd_data, l_note_out, l_play_pos;
  logic       l_note_valid, l_playing, l_done;
  logic [5:0] mem_b [0:63];

  int checks;
  int errors;

  playback_sequencer #(.NUM_POS(64), .POS_W(6), .NOTE_W(6), .END_CODE(63), .GAP_TICKS(2)) u_dut (
    .clk(clk), .reset(rst_n), .play(play), .stop(stop), .loop_en(loop_en),
    .beat_len(beat_len), .edit_busy(edit_busy), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .note_out(note_out), .note_valid(note_valid),
    .play_pos(play_pos), .playing(playing), .done(done)
  );

  playback_sequencer #(.NUM_POS(64), .POS_W(6), .NOTE_W(6), .END_CODE(63), .GAP_TICKS(0)) u_leg (
    .clk(clk), .reset(rst_n), .play(l_play), .stop(l_stop), .loop_en(l_loop_en),
    .beat_len(l_beat_len), .edit_busy(1'b0), .rd_en(l_rd_en), .rd_addr(l_rd_addr),
    .rd_data(l_rd_data), .note_out(l_note_out), .note_valid(l_note_valid),
    .play_pos(l_play_pos), .playing(l_playing), .done(l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered read ports, 1-cycle latency
  always @(posedge clk) begin
    if (rd_en)   rd_data   <= mem_a[rd_addr];
    if (l_rd_en) l_rd_data <= mem_b[l_rd_addr];
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_song();
    for (int i = 0; i < 64; i++) mem_a[i] = 6'd63;
    mem_a[0] = 6'd5;
    mem_a[1] = 6'd12;
    mem_a[2] = 6'd0;
    mem_a[3] = 6'd7;
    mem_a[4] = 6'd63;
  endtask

  task automatic to_idle();
    play = 1'b0;
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    checks++;
    if ({rd_en, rd_addr, note_out, note_valid, play_pos, playing, done} !== '0) begin
      errors++;
      $display("FAIL reset_state got %h want 0",
               {rd_en, rd_addr, note_out, note_valid, play_pos, playing, done});
    end
    // reset asserted in the middle of a note
    load_song();
    beat_len = 24'd4;
    play = 1'b1; tick(1); play = 1'b0;
    tick(5);
    checks++;
    if (note_valid !== 1'b1) begin
      errors++; $display("FAIL mid_play_nv got %b want 1", note_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_en, rd_addr, note_out, note_valid, play_pos, playing, done} !== '0) begin
      errors++;
      $display("FAIL async_reset got %h want 0",
               {rd_en, rd_addr, note_out, note_valid, play_pos, playing, done});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);
    play = 1'b1; tick(1); play = 1'b0;
    tick(1);
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 6'd0) begin
      errors++; $display("FAIL restart_read got en=%b addr=%0d want en=1 addr=0", rd_en, rd_addr);
    end
    tick(2);
    checks++;
    if (note_out !== 6'd5 || note_valid !== 1'b1) begin
      errors++; $display("FAIL restart_note got %0d/%b want 5/1", note_out, note_valid);
    end
    to_idle();
  endtask

  task automatic test_stop_priority();
    play = 1'b1; stop = 1'b1;
    tick(1);
    checks++;
    if (playing !== 1'b0) begin
      errors++; $display("FAIL stop_over_play got playing=%b want 0", playing);
    end
    play = 1'b0; stop = 1'b0;
    tick(1);
  endtask

  task automatic test_song();
    logic [5:0] song [0:3];
    int idx;
    logic exp_rd, exp_nv;
    song[0] = 6'd5; song[1] = 6'd12; song[2] = 6'd0; song[3] = 6'd7;
    load_song();
    beat_len = 24'd4;
    loop_en = 1'b0;
    play = 1'b1; tick(1); play = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick(1);
      exp_rd = (c <= 33) && ((c - 1) % 8 == 0);
      checks++;
      if (rd_en !== exp_rd) begin
        errors++; $display("FAIL song_rd_en c=%0d got %b want %b", c, rd_en, exp_rd);
      end
      if (exp_rd) begin
        checks++;
        if (rd_addr !== 6'((c - 1) / 8)) begin
          errors++; $display("FAIL song_rd_addr c=%0d got %0d want %0d", c, rd_addr, (c - 1) / 8);
        end
      end
      if (c >= 3) begin
        idx = (c - 3) / 8;
        if (idx > 3) idx = 3;
        exp_nv = ((c - 3) < 32) && (((c - 3) % 8) < 4) && (song[idx] != 6'd0);
        checks++;
        if (note_out !== song[idx] || note_valid !== exp_nv) begin
          errors++;
          $display("FAIL song_note c=%0d got %0d/%b want %0d/%b", c, note_out, note_valid, song[idx], exp_nv);
        end
      end
      checks++;
      if (done !== (c == 35) || playing !== (c <= 35)) begin
        errors++;
        $display("FAIL song_done c=%0d got done=%b playing=%b want %b/%b", c, done, playing, c == 35, c <= 35);
      end
    end
    to_idle();
  endtask

  task automatic test_loop_stop();
    int done_cnt;
    done_cnt = 0;
    load_song();
    beat_len = 24'd4;
    loop_en = 1'b1;
    play = 1'b1; tick(1); play = 1'b0;
    for (int c = 1; c <= 39; c++) begin
      tick(1);
      if (done) done_cnt++;
      if (c == 35) begin
        checks++;
        if (play_pos !== 6'd0) begin
          errors++; $display("FAIL loop_pos got %0d want 0", play_pos);
        end
      end
      if (c == 36) begin
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== 6'd0) begin
          errors++; $display("FAIL loop_reread got en=%b addr=%0d want 1/0", rd_en, rd_addr);
        end
      end
      if (c == 38) begin
        checks++;
        if (note_out !== 6'd5 || note_valid !== 1'b1) begin
          errors++; $display("FAIL loop_replay got %0d/%b want 5/1", note_out, note_valid);
        end
      end
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++; $display("FAIL loop_no_done got %0d pulses want 0", done_cnt);
    end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    checks++;
    if (note_valid !== 1'b0 || playing !== 1'b0 || play_pos !== 6'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL stop_outputs got nv=%b playing=%b pos=%0d done=%b want 0/0/0/0",
               note_valid, playing, play_pos, done);
    end
    loop_en = 1'b0;
    tick(2);
  endtask

  task automatic test_full_memory();
    int rd_cnt;
    for (int i = 0; i < 64; i++) mem_b[i] = 6'd9;
    l_beat_len = 24'd1;
    // single pass: 64 reads, done after the last note
    l_loop_en = 1'b0;
    rd_cnt = 0;
    l_play = 1'b1; tick(1); l_play = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      tick(1);
      if (l_rd_en) rd_cnt++;
      if (c == 3) begin
        checks++;
        if (l_note_out !== 6'd9 || l_note_valid !== 1'b1) begin
          errors++; $display("FAIL full_first got %0d/%b want 9/1", l_note_out, l_note_valid);
        end
      end
      if (c == 190) begin
        checks++;
        if (l_rd_en !== 1'b1 || l_rd_addr !== 6'd63) begin
          errors++; $display("FAIL full_last_read got en=%b addr=%0d want 1/63", l_rd_en, l_rd_addr);
        end
      end
      checks++;
      if (l_done !== (c == 193)) begin
        errors++; $display("FAIL full_done c=%0d got %b want %b", c, l_done, c == 193);
      end
    end
    checks++;
    if (rd_cnt !== 64 || l_playing !== 1'b0) begin
      errors++; $display("FAIL full_reads got %0d playing=%b want 64/0", rd_cnt, l_playing);
    end
    // looping: wraps 63 -> 0
    l_loop_en = 1'b1;
    l_play = 1'b1; tick(1); l_play = 1'b0;
    for (int c = 1; c <= 196; c++) begin
      tick(1);
      if (c == 194) begin
        checks++;
        if (l_rd_en !== 1'b1 || l_rd_addr !== 6'd0 || l_done !== 1'b0) begin
          errors++;
          $display("FAIL full_wrap got en=%b addr=%0d done=%b want 1/0/0", l_rd_en, l_rd_addr, l_done);
        end
      end
    end
    l_stop = 1'b1; tick(1); l_stop = 1'b0;
    l_loop_en = 1'b0;
    tick(1);
  endtask

  task automatic test_edit_busy();
    load_song();
    beat_len = 24'd4;
    edit_busy = 1'b1;
    play = 1'b1; tick(1); play = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      checks++;
      if (rd_en !== 1'b0 || play_pos !== 6'd0 || playing !== 1'b1) begin
        errors++;
        $display("FAIL edit_hold c=%0d got en=%b pos=%0d playing=%b want 0/0/1", c, rd_en, play_pos, playing);
      end
    end
    edit_busy = 1'b0;
    tick(1);
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 6'd0) begin
      errors++; $display("FAIL edit_release got en=%b addr=%0d want 1/0", rd_en, rd_addr);
    end
    tick(2);
    checks++;
    if (note_out !== 6'd5 || note_valid !== 1'b1) begin
      errors++; $display("FAIL edit_note got %0d/%b want 5/1", note_out, note_valid);
    end
    to_idle();
  endtask

  task automatic test_beat_change();
    load_song();
    beat_len = 24'd4;
    play = 1'b1; tick(1); play = 1'b0;
    tick(4);
    beat_len = 24'd2;   // mid-note: only the next note is shortened
    tick(2);
    checks++;
    if (note_valid !== 1'b1) begin
      errors++; $display("FAIL beat_keep c=6 got %b want 1", note_valid);
    end
    tick(1);
    checks++;
    if (note_valid !== 1'b0) begin
      errors++; $display("FAIL beat_end0 c=7 got %b want 0", note_valid);
    end
    tick(5);
    checks++;
    if (note_out !== 6'd12 || note_valid !== 1'b1) begin
      errors++; $display("FAIL beat_note1 c=12 got %0d/%b want 12/1", note_out, note_valid);
    end
    tick(1);
    checks++;
    if (note_valid !== 1'b0) begin
      errors++; $display("FAIL beat_end1 c=13 got %b want 0", note_valid);
    end
    to_idle();
  endtask

  task automatic test_beat_zero();
    load_song();
    beat_len = 24'd0;
    play = 1'b1; tick(1); play = 1'b0;
    tick(3);
    checks++;
    if (note_out !== 6'd5 || note_valid !== 1'b1) begin
      errors++; $display("FAIL zero_on c=3 got %0d/%b want 5/1", note_out, note_valid);
    end
    tick(1);
    checks++;
    if (note_valid !== 1'b0) begin
      errors++; $display("FAIL zero_off c=4 got %b want 0", note_valid);
    end
    tick(4);
    checks++;
    if (note_out !== 6'd12 || note_valid !== 1'b1) begin
      errors++; $display("FAIL zero_next c=8 got %0d/%b want 12/1", note_out, note_valid);
    end
    to_idle();
  endtask

  task automatic test_empty_song();
    int rd_cnt;
    int done_cnt;
    rd_cnt = 0;
    done_cnt = 0;
    mem_a[0] = 6'd63;
    loop_en = 1'b1;
    beat_len = 24'd4;
    play = 1'b1; tick(1); play = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      if (rd_en) rd_cnt++;
      if (done) done_cnt++;
      if (c == 3) begin
        checks++;
        if (done !== 1'b1) begin
          errors++; $display("FAIL empty_done c=3 got %b want 1", done);
        end
      end
    end
    checks++;
    if (rd_cnt !== 1 || done_cnt !== 1 || playing !== 1'b0) begin
      errors++;
      $display("FAIL empty_spin got reads=%0d dones=%0d playing=%b want 1/1/0", rd_cnt, done_cnt, playing);
    end
    loop_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    play = 1'b0; stop = 1'b0; loop_en = 1'b0; edit_busy = 1'b0; beat_len = 24'd4;
    l_play = 1'b0; l_stop = 1'b0; l_loop_en = 1'b0; l_beat_len = 24'd1;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 6'd63;
      mem_b[i] = 6'd9;
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    test_reset();
    test_stop_priority();
    test_song();
    test_loop_stop();
    test_full_memory();
    test_edit_busy();
    test_beat_change();
    test_beat_zero();
    test_empty_song();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
